// File: rtl/inst_buf.sv
// Instruction buffer between fetch and the two decode ways: a circular FIFO
// that accepts up to two instructions per cycle and presents the two oldest.
module inst_buf #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             fetch_valid_i,
    output logic             fetch_ready_o,
    input  logic [XLEN-1:0]  fetch_pc_i,
    input  logic [31:0]      fetch_inst0_i,
    input  logic [31:0]      fetch_inst1_i,
    input  logic [1:0]       fetch_mask_i,
    output logic [1:0]       dec_valid_o,
    output logic [31:0]      dec_inst0_o,
    output logic [31:0]      dec_inst1_o,
    output logic [XLEN-1:0]  dec_pc0_o,
    output logic [XLEN-1:0]  dec_pc1_o,
    input  logic [1:0]       dec_ack_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      inst_mem_r [DEPTH];
    logic [XLEN-1:0]  pc_mem_r   [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    logic [PTR_W-1:0] head1_s;
    logic [PTR_W-1:0] tail1_s;
    logic             enq_s;
    logic [1:0]       n_enq_s;
    logic [1:0]       n_deq_s;
    logic             slot0_vld_s;
    logic             slot1_vld_s;
    logic [XLEN-1:0]  pc_plus4_s;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

    // Readiness uses registered occupancy only, so a same-cycle pop never opens room.
    assign fetch_ready_o = !rst_i && !flush_i && (count_r <= CNT_W'(DEPTH - 2));
    assign enq_s         = fetch_valid_i && fetch_ready_o;
    assign n_enq_s       = enq_s ? popcount2(fetch_mask_i) : 2'd0;
    assign head1_s       = head_r + PTR_W'(1);
    assign tail1_s       = tail_r + PTR_W'(1);
    assign pc_plus4_s    = fetch_pc_i + XLEN'(4);

    assign slot0_vld_s   = (count_r >= CNT_W'(1));
    assign slot1_vld_s   = (count_r >= CNT_W'(2));
    assign dec_valid_o   = {slot1_vld_s, slot0_vld_s};
    assign dec_inst0_o   = slot0_vld_s ? inst_mem_r[head_r]  : 32'd0;
    assign dec_pc0_o     = slot0_vld_s ? pc_mem_r[head_r]    : XLEN'(0);
    assign dec_inst1_o   = slot1_vld_s ? inst_mem_r[head1_s] : 32'd0;
    assign dec_pc1_o     = slot1_vld_s ? pc_mem_r[head1_s]   : XLEN'(0);
    assign count_o       = count_r;

    // Pop count: acks for slots that are not valid are masked, ack 10 is ignored.
    always_comb begin
        n_deq_s = 2'd0;
        case (dec_ack_i)
            2'b01: begin
                if (slot0_vld_s) n_deq_s = 2'd1;
                else             n_deq_s = 2'd0;
            end
            2'b11: begin
                if (slot1_vld_s)      n_deq_s = 2'd2;
                else if (slot0_vld_s) n_deq_s = 2'd1;
                else                  n_deq_s = 2'd0;
            end
            default: n_deq_s = 2'd0;
        endcase
    end

    // Pointer and occupancy registers; reset outranks flush, flush outranks handshakes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            head_r  <= head_r + PTR_W'(n_deq_s);
            tail_r  <= tail_r + PTR_W'(n_enq_s);
            count_r <= count_r + CNT_W'(n_enq_s) - CNT_W'(n_deq_s);
        end
    end

    // Entry storage: valid slots are compacted and written in order from tail.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            case (fetch_mask_i)
                2'b01: begin
                    inst_mem_r[tail_r] <= fetch_inst0_i;
                    pc_mem_r[tail_r]   <= fetch_pc_i;
                end
                2'b10: begin
                    inst_mem_r[tail_r] <= fetch_inst1_i;
                    pc_mem_r[tail_r]   <= pc_plus4_s;
                end
                2'b11: begin
                    inst_mem_r[tail_r]  <= fetch_inst0_i;
                    pc_mem_r[tail_r]    <= fetch_pc_i;
                    inst_mem_r[tail1_s] <= fetch_inst1_i;
                    pc_mem_r[tail1_s]   <= pc_plus4_s;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_buf.sv
// Self-checking bench for inst_buf: a queue-based reference of buffer contents
// checked every cycle by a monitor, plus directed checks with hand-computed values.
module tb_inst_buf;

    localparam int DEPTH = 8;
    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_i, flush_i, fetch_valid_i, fetch_ready_o;
    logic [XLEN-1:0]  fetch_pc_i;
    logic [31:0]      fetch_inst0_i, fetch_inst1_i;
    logic [1:0]       fetch_mask_i, dec_valid_o, dec_ack_i;
    logic [31:0]      dec_inst0_o, dec_inst1_o;
    logic [XLEN-1:0]  dec_pc0_o, dec_pc1_o;
    logic [CNT_W-1:0] count_o;

    inst_buf #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .fetch_pc_i(fetch_pc_i), .fetch_inst0_i(fetch_inst0_i),
        .fetch_inst1_i(fetch_inst1_i), .fetch_mask_i(fetch_mask_i),
        .dec_valid_o(dec_valid_o), .dec_inst0_o(dec_inst0_o),
        .dec_inst1_o(dec_inst1_o), .dec_pc0_o(dec_pc0_o), .dec_pc1_o(dec_pc1_o),
        .dec_ack_i(dec_ack_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } ent_t;

    ent_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic started  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] inst_of(input logic [XLEN-1:0] pc);
        return pc[31:0] ^ 32'h5A00_0013;
    endfunction

    // Monitor: compares outputs to the reference queue, then applies this cycle's handshakes.
    int         mon_sz;
    int         mon_deq;
    logic       mon_rdy;
    logic [1:0] mon_ev;
    always @(negedge clk) begin
        if (started) begin
            mon_sz  = sb_q.size();
            mon_ev  = (mon_sz >= 2) ? 2'b11 : ((mon_sz == 1) ? 2'b01 : 2'b00);
            mon_rdy = !rst_i && !flush_i && (mon_sz <= DEPTH - 2);
            check("mon_count", 64'(count_o), 64'(mon_sz));
            check("mon_dec_valid", 64'(dec_valid_o), 64'(mon_ev));
            check("mon_fetch_ready", 64'(fetch_ready_o), 64'(mon_rdy));
            check("mon_inst0", 64'(dec_inst0_o), mon_ev[0] ? 64'(sb_q[0].inst) : 64'd0);
            check("mon_pc0", dec_pc0_o, mon_ev[0] ? sb_q[0].pc : 64'd0);
            check("mon_inst1", 64'(dec_inst1_o), mon_ev[1] ? 64'(sb_q[1].inst) : 64'd0);
            check("mon_pc1", dec_pc1_o, mon_ev[1] ? sb_q[1].pc : 64'd0);
            if (rst_i || flush_i) begin
                sb_q.delete();
            end else begin
                mon_deq = 0;
                if (dec_ack_i == 2'b01 && mon_ev[0]) mon_deq = 1;
                if (dec_ack_i == 2'b11) mon_deq = mon_ev[1] ? 2 : (mon_ev[0] ? 1 : 0);
                for (int k = 0; k < mon_deq; k++) void'(sb_q.pop_front());
                if (fetch_valid_i && mon_rdy) begin
                    if (fetch_mask_i[0]) sb_q.push_back({fetch_inst0_i, fetch_pc_i});
                    if (fetch_mask_i[1]) sb_q.push_back({fetch_inst1_i, fetch_pc_i + 64'd4});
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [1:0] m, input logic [1:0] ack,
                         input logic fl, input logic rs);
        fetch_valid_i = v;  fetch_pc_i   = pc;  fetch_inst0_i = i0;
        fetch_inst1_i = i1; fetch_mask_i = m;   dec_ack_i     = ack;
        flush_i       = fl; rst_i        = rs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pkt(input logic [XLEN-1:0] pc, input logic [1:0] m, input logic [1:0] ack);
        drive(1'b1, pc, inst_of(pc), inst_of(pc + 64'd4), m, ack, 1'b0, 1'b0);
        step();
    endtask

    task automatic idle(input logic [1:0] ack, input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 64'd0, 32'd0, 32'd0, 2'b00, ack, 1'b0, 1'b0);
            step();
        end
    endtask

    logic [XLEN-1:0] spc;
    int              r;

    initial begin
        drive(1'b0, 64'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
        step();
        step();
        started = 1'b1;
        check("reset_count", 64'(count_o), 64'd0);
        check("reset_valid", 64'(dec_valid_o), 64'd0);
        check("reset_ready", 64'(fetch_ready_o), 64'd0);

        // Two-instruction packet, visible one cycle later
        drive(1'b1, 64'h1000, 32'h0050_0093, 32'h00A0_0113, 2'b11, 2'b00, 1'b0, 1'b0);
        step();
        check("p1_valid", 64'(dec_valid_o), 64'h3);
        check("p1_pc0", dec_pc0_o, 64'h1000);
        check("p1_pc1", dec_pc1_o, 64'h1004);
        check("p1_inst0", 64'(dec_inst0_o), 64'h0050_0093);
        check("p1_count", 64'(count_o), 64'd2);
        idle(2'b11, 1);
        check("p1_drained", 64'(count_o), 64'd0);

        // Slot-1-only packet is compacted into slot 0
        drive(1'b1, 64'h2000, 32'h0050_0093, 32'h00A0_0113, 2'b10, 2'b00, 1'b0, 1'b0);
        step();
        check("p2_valid", 64'(dec_valid_o), 64'h1);
        check("p2_inst0", 64'(dec_inst0_o), 64'h00A0_0113);
        check("p2_pc0", dec_pc0_o, 64'h2004);
        check("p2_count", 64'(count_o), 64'd1);
        idle(2'b01, 1);

        // Fill to full, then ack with a blocked packet pending
        pkt(64'h3000, 2'b11, 2'b00);
        pkt(64'h3008, 2'b11, 2'b00);
        pkt(64'h3010, 2'b11, 2'b00);
        check("fill_count6", 64'(count_o), 64'd6);
        check("fill_ready6", 64'(fetch_ready_o), 64'd1);
        pkt(64'h3018, 2'b11, 2'b00);
        check("fill_count8", 64'(count_o), 64'd8);
        check("fill_ready8", 64'(fetch_ready_o), 64'd0);
        pkt(64'h3020, 2'b11, 2'b11);
        check("fill_ack_count", 64'(count_o), 64'd6);
        check("fill_ack_ready", 64'(fetch_ready_o), 64'd1);
        check("fill_head_pc", dec_pc0_o, 64'h3008);
        pkt(64'h3020, 2'b11, 2'b00);
        check("fill_refill", 64'(count_o), 64'd8);
        idle(2'b11, 4);
        check("fill_drained", 64'(count_o), 64'd0);

        // Random stream across pointer wrap
        spc = 64'h4000;
        for (int c = 0; c < 20; c++) begin
            r = $urandom_range(0, 2);
            drive($urandom_range(0, 3) != 0, spc, inst_of(spc), inst_of(spc + 64'd4),
                  2'($urandom_range(0, 3)), (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11),
                  1'b0, 1'b0);
            step();
            spc = spc + 64'd8;
        end
        idle(2'b11, 5);
        check("stream_drained", 64'(count_o), 64'd0);

        // Flush with simultaneous packet and ack
        pkt(64'h5000, 2'b11, 2'b00);
        pkt(64'h5008, 2'b11, 2'b00);
        pkt(64'h5010, 2'b01, 2'b00);
        check("flush_pre_count", 64'(count_o), 64'd5);
        drive(1'b1, 64'h5800, inst_of(64'h5800), inst_of(64'h5804), 2'b11, 2'b11, 1'b1, 1'b0);
        #1;
        check("flush_ready", 64'(fetch_ready_o), 64'd0);
        check("flush_valid_pre", 64'(dec_valid_o), 64'h3);
        step();
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(dec_valid_o), 64'd0);
        pkt(64'h6000, 2'b01, 2'b00);
        check("post_flush_count", 64'(count_o), 64'd1);
        check("post_flush_pc0", dec_pc0_o, 64'h6000);
        idle(2'b01, 1);

        // Reset mid-stream with a packet offered
        pkt(64'h7000, 2'b11, 2'b00);
        pkt(64'h7008, 2'b11, 2'b00);
        check("rst_pre_count", 64'(count_o), 64'd4);
        drive(1'b1, 64'h7010, inst_of(64'h7010), inst_of(64'h7014), 2'b11, 2'b00, 1'b0, 1'b1);
        #1;
        check("rst_ready", 64'(fetch_ready_o), 64'd0);
        step();
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(dec_valid_o), 64'd0);
        check("rst_pc0", dec_pc0_o, 64'd0);
        idle(2'b00, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_buf.md
Name: inst_buf

Overview:
Instruction buffer between fetch and the two decode ways; it is the producer side of the per-way instruction interface.
- Accepts fetch packets of up to two 32-bit instructions with their PC.
- Stores them in order in a circular FIFO.
- Presents the two oldest instructions, with their PCs, to decode slots 0 and 1.
- Decode acknowledges in order; flush empties the buffer on redirect.

Parameters:
DEPTH, 8, number of instruction entries; power of 2, minimum 4
XLEN, 64, PC width
CNT_W, $clog2(DEPTH)+1, width of count_o

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous active-high reset
flush_i  input  1  synchronous clear of all entries (branch redirect / exception)
fetch_valid_i  input  1  fetch packet valid
fetch_ready_o  output  1  buffer can accept a packet this cycle
fetch_pc_i  input  XLEN  PC of slot 0 of the packet; slot 1 PC = fetch_pc_i+4
fetch_inst0_i  input  32  instruction in packet slot 0
fetch_inst1_i  input  32  instruction in packet slot 1
fetch_mask_i  input  2  per-slot valid: bit0=slot0, bit1=slot1
dec_valid_o  output  2  bit k: decode slot k holds a valid instruction
dec_inst0_o  output  32  oldest instruction
dec_inst1_o  output  32  second-oldest instruction
dec_pc0_o  output  XLEN  PC of dec_inst0_o
dec_pc1_o  output  XLEN  PC of dec_inst1_o
dec_ack_i  input  2  decode consumed slots: 2'b01 pops one, 2'b11 pops two
count_o  output  CNT_W  number of occupied entries

Behaviour:
State and storage:
- Storage: DEPTH entries of {inst[31:0], pc[XLEN-1:0]}.
- head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count register runs 0..DEPTH.

Reset (rst_i=1):
- Next edge: head=0, tail=0, count=0.
- Entry contents need no reset.
- During and after reset: dec_valid_o=2'b00, all dec_* data outputs 0, count_o=0.
- fetch_ready_o is forced to 0 while rst_i=1.
- rst_i has priority over flush_i and over all handshakes.

fetch_ready_o:
- fetch_ready_o = !rst_i && !flush_i && (count <= DEPTH-2).
- It depends on the registered count only; a same-cycle dequeue does not open room.

Enqueue:
- Condition: fetch_valid_i && fetch_ready_o.
- Valid slots are written compacted and in order starting at tail:
  - mask 01: write inst0/pc at tail.
  - mask 10: write inst1 with pc+4 at tail.
  - mask 11: write inst0/pc at tail, and inst1/pc+4 at tail+1 (mod DEPTH).
  - mask 00: accepted, nothing written.
- tail advances by n_enq = popcount(mask).

Dequeue:
- dec_valid_o[0] = (count>=1); dec_valid_o[1] = (count>=2).
- Slot 0 shows entry[head]; slot 1 shows entry[head+1 mod DEPTH].
- Outputs come combinationally from registered state. There is no bypass: an enqueued instruction is visible on dec_* the cycle after acceptance (1-cycle latency).
- dec_inst*/dec_pc* are 0 when the corresponding dec_valid_o bit is 0.
- n_deq is 1 for ack 01 (requires dec_valid_o[0]) and 2 for ack 11 (requires both valid bits); head advances by n_deq.
- The following are ignored (n_deq=0): ack bits for invalid slots, and ack 10. An ack 11 with only slot 0 valid pops one.

Simultaneous events:
- count_next = count + n_enq - n_deq.
- Enqueue and dequeue in the same cycle are both honoured, including at wrap-around.

Flush (flush_i=1, rst_i=0):
- Next edge: head=tail=0, count=0.
- Any enqueue or ack in the flush cycle is discarded.
- fetch_ready_o=0 in the flush cycle; dec_valid_o still reflects pre-flush contents in that cycle.

Boundaries:
- count never exceeds DEPTH, guaranteed by the ready rule.
- The buffer never underflows, guaranteed by ack masking.
- count=DEPTH-1 gives fetch_ready_o=0 even when the packet mask is 01.

Assertions (verification):
- count == (tail-head) mod DEPTH, except full, where count=DEPTH.
- dec_valid_o is always 00, 01 or 11.

Test Plan:
- Reset then one packet {pc=0x1000, inst0=0x00500093, inst1=0x00A00113, mask=11} -> the next cycle shows dec_valid_o=11, dec_pc0_o=0x1000, dec_pc1_o=0x1004, count_o=2.
- Packet with mask=10, pc=0x2000 into an empty buffer -> dec_valid_o=01, dec_inst0_o=inst1, dec_pc0_o=0x2004, count_o=1.
- Fill with 3 packets of mask=11 (DEPTH=8, count=6), then a 4th packet, then ack 11 the same cycle as a 5th packet -> the 4th is accepted with count reaching 8 and fetch_ready_o=0. The 5th is not accepted in the ack cycle. The following cycle has count=6 and fetch_ready_o=1.
- Stream for 20 cycles with a random mask each cycle and ack random in {00,01,11}, cycling pointers past wrap -> dec PCs come out in strictly program order with no loss or duplication; count_o always matches a reference model.
- Buffer with count=5, assert flush_i together with fetch_valid_i and ack 11 -> the next cycle has count_o=0 and dec_valid_o=00. The dropped packet does not appear, and new packets are accepted the cycle after.
- Assert rst_i mid-stream with count=4 and fetch_valid_i=1 -> fetch_ready_o=0 during reset; the next cycle has count_o=0, dec_valid_o=00, dec_pc0_o=0.
